// File: rtl/ltc2308_conv_ctrl.sv
// ltc2308_conv_ctrl
// Conversion and serial controller for the LTC2308 ADC. One start request
// runs one frame: hold CONVST high for the conversion time, then clock 12
// SCK periods. During those periods the 6-bit config word goes out on SDI
// and the result comes back on SDO. The config word sent in a frame selects
// the channel for the *next* conversion. The block therefore tags each
// sample with the channel requested one frame earlier. The first frame
// after reset only primes the ADC, so it produces no sample.
//
// Ports:
//   clk_clk, reset_reset      system clock; async active-high reset
//   start, channel, unipolar  request; accepted only while busy=0
//   busy                      frame in progress (start ignored)
//   sample_valid              one-cycle strobe for sample_data/sample_channel
//   sample_data[11:0]         conversion result, held between strobes
//   sample_channel[2:0]       channel sample_data was converted on
//   adc_convst/sck/sdi/sdo    LTC2308 pins
//
// Handshake: start is a single-cycle request. It is taken only in a cycle
// where busy=0, and is dropped (not queued) otherwise. sample_valid is a
// one-cycle strobe with no back-pressure.
module ltc2308_conv_ctrl #(
    parameter int SCK_DIV     = 2,
    parameter int CONV_CYCLES = 80
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic        start,
    input  logic [2:0]  channel,
    input  logic        unipolar,
    output logic        busy,
    output logic        sample_valid,
    output logic [11:0] sample_data,
    output logic [2:0]  sample_channel,
    output logic        adc_convst,
    output logic        adc_sck,
    output logic        adc_sdi,
    input  logic        adc_sdo
);

    localparam int CNT_MAX = (CONV_CYCLES > 2 * SCK_DIV) ? CONV_CYCLES : 2 * SCK_DIV;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {IDLE, CONV, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_q, bit_d;
    logic [2:0]       cur_ch_q, cur_ch_d;
    logic             cur_uni_q, cur_uni_d;
    logic [11:0]      shift_q;
    logic             primed_q;
    logic [2:0]       prev_ch_q;
    logic             valid_q;
    logic [11:0]      data_q;
    logic [2:0]       chan_q;
    logic             busy_q, busy_d;
    logic             convst_q, convst_d;
    logic             sck_q, sck_d;
    logic             sdi_q, sdi_d;
    logic [5:0]       cfg_word;
    logic             shift_en;
    logic             done_enter;

    // Config word in transmit order, bit 0 first:
    // S/D=1, O/S=ch[0], S1=ch[2], S0=ch[1], UNI, SLP=0
    assign cfg_word = {1'b0, cur_uni_q, cur_ch_q[1], cur_ch_q[2], cur_ch_q[0], 1'b1};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        cur_ch_d  = cur_ch_q;
        cur_uni_d = cur_uni_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = CONV;
                    cnt_d     = '0;
                    cur_ch_d  = channel;
                    cur_uni_d = unipolar;
                end
            end
            CONV: begin
                if (cnt_q == CNT_W'(CONV_CYCLES - 1)) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    bit_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SHIFT: begin
                // cnt_q walks one SCK period: low half, then high half.
                if (cnt_q == CNT_W'(2 * SCK_DIV - 1)) begin
                    cnt_d = '0;
                    if (bit_q == 4'd11) begin
                        state_d = DONE;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pin values are decoded from the next state and registered, so the
    // pins change cleanly on the clock edge and stay aligned with the state.
    always_comb begin
        busy_d   = (state_d != IDLE);
        convst_d = (state_d == CONV);
        sck_d    = (state_d == SHIFT) && (cnt_d >= CNT_W'(SCK_DIV));
        sdi_d    = 1'b0;
        if (state_d == SHIFT && bit_d < 4'd6) begin
            sdi_d = cfg_word[bit_d[2:0]];
        end
    end

    // SDO is captured on the edge where SCK rises.
    assign shift_en   = (state_q == SHIFT) && (cnt_q == CNT_W'(SCK_DIV - 1));
    assign done_enter = (state_q == SHIFT) && (state_d == DONE);

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            cur_ch_q  <= '0;
            cur_uni_q <= 1'b0;
            shift_q   <= '0;
            primed_q  <= 1'b0;
            prev_ch_q <= '0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            chan_q    <= '0;
            busy_q    <= 1'b0;
            convst_q  <= 1'b0;
            sck_q     <= 1'b0;
            sdi_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            cur_ch_q  <= cur_ch_d;
            cur_uni_q <= cur_uni_d;
            busy_q    <= busy_d;
            convst_q  <= convst_d;
            sck_q     <= sck_d;
            sdi_q     <= sdi_d;
            if (shift_en) begin
                shift_q <= {shift_q[10:0], adc_sdo};
            end
            // The data read back now was converted on the channel that the
            // previous frame configured. A priming frame has no such
            // channel, so its data is dropped.
            valid_q <= done_enter && primed_q;
            if (done_enter) begin
                if (primed_q) begin
                    data_q <= shift_q;
                    chan_q <= prev_ch_q;
                end
                primed_q  <= 1'b1;
                prev_ch_q <= cur_ch_q;
            end
        end
    end

    assign busy           = busy_q;
    assign sample_valid   = valid_q;
    assign sample_data    = data_q;
    assign sample_channel = chan_q;
    assign adc_convst     = convst_q;
    assign adc_sck        = sck_q;
    assign adc_sdi        = sdi_q;

endmodule

// File: tb/tb_ltc2308_conv_ctrl.sv
// Testbench for ltc2308_conv_ctrl. The first instance uses the default
// timing and drives a behavioural LTC2308 model. The second instance uses
// SCK_DIV=1, CONV_CYCLES=100, with SDO tied high.
module tb_ltc2308_conv_ctrl;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #10 clk = ~clk;

    // ---------------- DUT 1 (defaults) ----------------
    logic        start = 1'b0;
    logic [2:0]  channel = '0;
    logic        unipolar = 1'b0;
    logic        busy, sample_valid;
    logic [11:0] sample_data;
    logic [2:0]  sample_channel;
    logic        adc_convst, adc_sck, adc_sdi, adc_sdo;

    ltc2308_conv_ctrl dut (
        .clk_clk(clk), .reset_reset(rst), .start(start), .channel(channel),
        .unipolar(unipolar), .busy(busy), .sample_valid(sample_valid),
        .sample_data(sample_data), .sample_channel(sample_channel),
        .adc_convst(adc_convst), .adc_sck(adc_sck), .adc_sdi(adc_sdi),
        .adc_sdo(adc_sdo)
    );

    // ---------------- DUT 2 (fast SCK, long conversion) ----------------
    logic        start2 = 1'b0;
    logic [2:0]  channel2 = '0;
    logic        busy2, sample_valid2;
    logic [11:0] sample_data2;
    logic [2:0]  sample_channel2;
    logic        adc_convst2, adc_sck2, adc_sdi2;
    logic        adc_sdo2 = 1'b1;

    ltc2308_conv_ctrl #(.SCK_DIV(1), .CONV_CYCLES(100)) dut2 (
        .clk_clk(clk), .reset_reset(rst), .start(start2), .channel(channel2),
        .unipolar(1'b0), .busy(busy2), .sample_valid(sample_valid2),
        .sample_data(sample_data2), .sample_channel(sample_channel2),
        .adc_convst(adc_convst2), .adc_sck(adc_sck2), .adc_sdi(adc_sdi2),
        .adc_sdo(adc_sdo2)
    );

    // ---------------- LTC2308 model ----------------
    // The word is loaded when CONVST rises, and is presented MSB first once
    // CONVST falls. It advances on each falling SCK edge. SDI is captured on
    // each rising SCK edge.
    logic [11:0] next_word = '0;
    logic [11:0] adc_word = '0;
    logic [11:0] sdi_cap = '0;
    int          bit_idx = 12;

    always @(posedge adc_convst) adc_word = next_word;
    always @(negedge adc_convst) bit_idx = 0;
    always @(negedge adc_sck) bit_idx = bit_idx + 1;
    always @(posedge adc_sck) if (bit_idx < 12) sdi_cap[bit_idx] = adc_sdi;
    assign adc_sdo = (bit_idx < 12) ? adc_word[11 - bit_idx] : 1'b0;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    // Each entry is {channel tag, data}.
    logic [14:0] exp_q[$];
    logic        tb_primed = 1'b0;
    logic [2:0]  tb_prev_ch = '0;

    always @(negedge clk) begin
        if (sample_valid) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_valid", 32'd1, 32'd0);
            end else begin
                logic [14:0] e;
                e = exp_q.pop_front();
                check_eq("sample_data", 32'(sample_data), 32'(e[11:0]));
                check_eq("sample_channel", 32'(sample_channel), 32'(e[14:12]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Call this at a negedge with DUT 1 idle. It returns at the negedge
    // where busy is first seen low, so back-to-back calls give the minimum
    // frame period.
    task automatic run_frame(input logic [2:0] ch, input logic uni, input logic [11:0] word,
                             input int abort_at, input bit pulse_mid);
        int busy_low = 0, conv_cnt = 0, rises = 0, first_rise = 0;
        int valid_cnt = 0, valid_cyc = 0, sdi_bad = 0;
        logic prev_sck = 1'b0;
        bit aborted = 1'b0;
        bit expect_valid;
        logic [11:0] exp_sdi;
        expect_valid = tb_primed && (abort_at == 0);
        if (expect_valid) exp_q.push_back({tb_prev_ch, word});
        // Bits 0..5 carry S/D, O/S, S1, S0, UNI, SLP; bits 6..11 carry 0.
        exp_sdi = {6'b0, 1'b0, uni, ch[1], ch[2], ch[0], 1'b1};
        next_word = word;
        sdi_cap = '0;
        channel = ch;
        unipolar = uni;
        start = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 300; n++) begin
            @(negedge clk);
            if (n == 1) begin
                start = 1'b0;
                check_eq("busy_cycle1", 32'(busy), 32'd1);
            end
            if (pulse_mid && (n == 40 || n == 100)) begin
                start = 1'b1;
                channel = ~ch;
                unipolar = ~uni;
            end else if (pulse_mid && (n == 41 || n == 101)) begin
                start = 1'b0;
                channel = ch;
                unipolar = uni;
            end
            if (n == abort_at) begin
                rst = 1'b1;
                #1;
                check_eq("abort_sck", 32'(adc_sck), 32'd0);
                check_eq("abort_convst", 32'(adc_convst), 32'd0);
                check_eq("abort_busy", 32'(busy), 32'd0);
                @(negedge clk);
                rst = 1'b0;
                aborted = 1'b1;
                break;
            end
            if (adc_convst) conv_cnt++;
            if (adc_sck && !prev_sck) begin
                rises++;
                if (rises == 1) first_rise = n;
            end
            prev_sck = adc_sck;
            if (sample_valid) begin
                valid_cnt++;
                valid_cyc = n;
            end
            if (adc_sdi && (n <= 80 || n >= 129)) sdi_bad++;
            if (!busy) begin
                busy_low = n;
                break;
            end
        end
        if (aborted) begin
            check_eq("abort_no_valid", 32'(valid_cnt), 32'd0);
            tb_primed = 1'b0;
            tb_prev_ch = '0;
        end else begin
            check_eq("busy_low_cycle", 32'(busy_low), 32'd130);
            check_eq("convst_cycles", 32'(conv_cnt), 32'd80);
            check_eq("sck_pulses", 32'(rises), 32'd12);
            check_eq("first_sck_rise", 32'(first_rise), 32'd83);
            check_eq("valid_count", 32'(valid_cnt), expect_valid ? 32'd1 : 32'd0);
            if (expect_valid) check_eq("valid_cycle", 32'(valid_cyc), 32'd129);
            check_eq("sdi_bits", 32'(sdi_cap), 32'(exp_sdi));
            check_eq("sdi_idle_zero", 32'(sdi_bad), 32'd0);
            tb_primed = 1'b1;
            tb_prev_ch = ch;
        end
    endtask

    // DUT 2: DONE falls at 1 + 100 + 24 = 125, and busy drops at 126.
    task automatic run_frame2(input logic [2:0] ch, input bit expect_valid, input logic [2:0] exp_ch);
        int busy_low = 0, valid_cnt = 0, valid_cyc = 0, conv_cnt = 0;
        logic [11:0] got_data = '0;
        logic [2:0] got_ch = '0;
        channel2 = ch;
        start2 = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 300; n++) begin
            @(negedge clk);
            if (n == 1) start2 = 1'b0;
            if (adc_convst2) conv_cnt++;
            if (sample_valid2) begin
                valid_cnt++;
                valid_cyc = n;
                got_data = sample_data2;
                got_ch = sample_channel2;
            end
            if (!busy2) begin
                busy_low = n;
                break;
            end
        end
        check_eq("d2_busy_low", 32'(busy_low), 32'd126);
        check_eq("d2_convst_cycles", 32'(conv_cnt), 32'd100);
        check_eq("d2_valid_count", 32'(valid_cnt), expect_valid ? 32'd1 : 32'd0);
        if (expect_valid) begin
            check_eq("d2_valid_cycle", 32'(valid_cyc), 32'd125);
            check_eq("d2_data", 32'(got_data), 32'hFFF);
            check_eq("d2_channel", 32'(got_ch), 32'(exp_ch));
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_valid", 32'(sample_valid), 32'd0);
        check_eq("rst_data", 32'(sample_data), 32'd0);
        check_eq("rst_channel", 32'(sample_channel), 32'd0);
        check_eq("rst_convst", 32'(adc_convst), 32'd0);
        check_eq("rst_sck", 32'(adc_sck), 32'd0);
        check_eq("rst_sdi", 32'(adc_sdi), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_frame(3'd3, 1'b0, 12'h123, 0, 1'b0);    // priming frame, no sample
        run_frame(3'd5, 1'b0, 12'hA5C, 0, 1'b0);    // sample tagged ch 3
        run_frame(3'd0, 1'b1, 12'h3C7, 0, 1'b0);    // sample tagged ch 5
        run_frame(3'd6, 1'b0, 12'h5A1, 0, 1'b1);    // stray starts ignored
        run_frame(3'd2, 1'b0, 12'h999, 106, 1'b0);  // reset during bit 6
        run_frame(3'd4, 1'b0, 12'h777, 0, 1'b0);    // priming again
        run_frame(3'd1, 1'b1, 12'h0F0, 0, 1'b0);    // sample tagged ch 4
        for (int i = 0; i < 4; i++) begin
            run_frame(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                      12'($urandom_range(0, 4095)), 0, 1'b0);
        end
        repeat (3) @(negedge clk);
        check_eq("queue_empty", 32'(exp_q.size()), 32'd0);

        run_frame2(3'd2, 1'b0, 3'd0);
        run_frame2(3'd6, 1'b1, 3'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
